// File: rtl/page_xfer_seq_pkg.sv
// page_xfer_seq_pkg: shared definitions for the page/context transfer path.
// Holds the op and dir encodings, which the control unit and the HD address
// adder also use, plus the sequencer FSM state type.
package page_xfer_seq_pkg;

  localparam logic [1:0] OP_CONTEXT = 2'b01;  // SR/LR region
  localparam logic [1:0] OP_PAGE    = 2'b10;  // store/load region

  localparam logic DIR_SAVE = 1'b0;  // mem -> HD
  localparam logic DIR_LOAD = 1'b1;  // HD -> mem

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } xfer_state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_CONTEXT) || (op == OP_PAGE);
  endfunction

endpackage

// File: rtl/page_xfer_seq_if.sv
// page_xfer_seq_if: bundle of control-unit, HD and main-memory signals of the
// transfer sequencer.
//   slave  modport: the sequencer (takes start/op/dir/pid/mem_base and read
//                   data, drives index/pid_buffer/flag_inst_type, strobes,
//                   write data, mem_addr, busy/done/err)
//   master modport: the surrounding control unit, HD and memory
// Optional macro XFER_CHECKSUM_EN adds the checksum signal.
interface page_xfer_seq_if #(
  parameter int DATA_W  = 32,
  parameter int MADDR_W = 10
);
  import page_xfer_seq_pkg::*;

  logic               start;
  logic [1:0]         op;
  logic               dir;
  logic [13:0]        pid;
  logic [MADDR_W-1:0] mem_base;
  logic [7:0]         index;
  logic [13:0]        pid_buffer;
  logic [1:0]         flag_inst_type;
  logic [DATA_W-1:0]  hd_rdata;
  logic               hd_we;
  logic [DATA_W-1:0]  hd_wdata;
  logic [MADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;
  logic               busy;
  logic               done;
  logic               err;
`ifdef XFER_CHECKSUM_EN
  logic [DATA_W-1:0]  checksum;
`endif

  modport slave (
    input  start, op, dir, pid, mem_base, hd_rdata, mem_rdata,
`ifdef XFER_CHECKSUM_EN
    output checksum,
`endif
    output index, pid_buffer, flag_inst_type, hd_we, hd_wdata, mem_addr,
           mem_we, mem_wdata, busy, done, err
  );

  modport master (
    output start, op, dir, pid, mem_base, hd_rdata, mem_rdata,
`ifdef XFER_CHECKSUM_EN
    input  checksum,
`endif
    input  index, pid_buffer, flag_inst_type, hd_we, hd_wdata, mem_addr,
           mem_we, mem_wdata, busy, done, err
  );

endinterface

// File: rtl/xfer_index_ctr.sv
// xfer_index_ctr: 8-bit word index counter for the transfer sequencer.
//   clock, reset : system clock, asynchronous active-low reset
//   clr          : synchronous clear to 0 (wins over en)
//   en           : advance by one; holds at WORDS-1 instead of wrapping
//   count        : current index
//   tc           : terminal count, high while count == WORDS-1
module xfer_index_ctr #(
  parameter int WORDS = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count,
  output logic       tc
);

  localparam logic [7:0] LAST = 8'(WORDS - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == LAST);

endmodule

// File: rtl/page_xfer_seq.sv
// page_xfer_seq: sequencer for whole-page and context transfers between main
// memory and the HD. Each word takes two cycles: RD presents the index to both
// memories, WR routes the source read data to the destination and strobes it.
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : page_xfer_seq_if.slave (control, HD and memory signals)
// Optional macro XFER_CHECKSUM_EN adds a running sum of the written words.
module page_xfer_seq #(
  parameter int WORDS   = 40,
  parameter int DATA_W  = 32,
  parameter int MADDR_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  page_xfer_seq_if.slave  bus
);
  import page_xfer_seq_pkg::*;

  xfer_state_e        state_q, state_d;
  logic [13:0]        pid_q, pid_d;
  logic [1:0]         op_q, op_d;
  logic               dir_q, dir_d;
  logic [MADDR_W-1:0] base_q, base_d;

  logic              ctr_clr, ctr_en, ctr_tc;
  logic [7:0]        idx;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] wdata_c;
  logic              hd_we_c, mem_we_c, err_c, accept_c;

  xfer_index_ctr #(.WORDS(WORDS)) u_ctr (
    .clock (clock),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .count (idx),
    .tc    (ctr_tc)
  );

  // Both memories have one-cycle read latency, so in WR the read data belongs
  // to the index presented during the preceding RD.
  assign src_data = (dir_q == DIR_SAVE) ? bus.mem_rdata : bus.hd_rdata;

  always_comb begin
    state_d  = state_q;
    pid_d    = pid_q;
    op_d     = op_q;
    dir_d    = dir_q;
    base_d   = base_q;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    hd_we_c  = 1'b0;
    mem_we_c = 1'b0;
    err_c    = 1'b0;
    accept_c = 1'b0;
    wdata_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_is_legal(bus.op)) begin
            accept_c = 1'b1;
            pid_d    = bus.pid;
            op_d     = bus.op;
            dir_d    = bus.dir;
            base_d   = bus.mem_base;
            ctr_clr  = 1'b1;
            state_d  = ST_RD;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        wdata_c  = src_data;
        hd_we_c  = (dir_q == DIR_SAVE);
        mem_we_c = (dir_q == DIR_LOAD);
        // Clearing on the last word lets DONE already show index 0.
        if (ctr_tc) begin
          ctr_clr = 1'b1;
          state_d = ST_DONE;
        end else begin
          ctr_en  = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pid_q   <= '0;
      op_q    <= '0;
      dir_q   <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      base_q  <= base_d;
    end
  end

`ifdef XFER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept_c)               csum_d = '0;
    else if (state_q == ST_WR)  csum_d = csum_q + src_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign bus.checksum = csum_q;
`endif

  assign bus.index          = idx;
  assign bus.pid_buffer     = pid_q;
  assign bus.flag_inst_type = op_q;
  assign bus.mem_addr       = base_q + MADDR_W'(idx);  // wraps modulo 2^MADDR_W
  assign bus.hd_we          = hd_we_c;
  assign bus.mem_we         = mem_we_c;
  assign bus.hd_wdata       = wdata_c;
  assign bus.mem_wdata      = wdata_c;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.err            = err_c;

endmodule

// File: doc/page_xfer_seq.md
Name: page_xfer_seq

Overview:
- Sequencer for whole-page and context transfers between main memory and the HD.
- Steps a word index 0..WORDS-1 and drives the index, pid_buffer and flag_inst_type inputs of the HD effective-address adder.
- Issues one read and one write per word using synchronous single-cycle-latency memories.
- Sits between the control unit (start/op) and the HD/main-memory ports.

Parameters:
WORDS, 40, words per page/context block (index range 0..WORDS-1, WORDS<=256)
DATA_W, 32, data word width
MADDR_W, 10, main-memory address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request pulse, sampled only in IDLE
op  in  2  01 = context (SR/LR region), 10 = page (store/load region); 00/11 illegal
dir  in  1  0 = mem->HD (save/store), 1 = HD->mem (restore/load)
pid  in  14  process id, latched at start
mem_base  in  MADDR_W  main-memory start address, latched at start
index  out  8  word index to address adder
pid_buffer  out  14  latched pid to address adder
flag_inst_type  out  2  latched op to address adder
hd_rdata  in  DATA_W  HD read data, valid cycle after read
hd_we  out  1  HD write strobe (address = adder output)
hd_wdata  out  DATA_W  HD write data
mem_addr  out  MADDR_W  mem_base_latched + index
mem_rdata  in  DATA_W  memory read data, valid cycle after read
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on illegal op

Behaviour:
- Reset values: all outputs 0.
- On reset, state=IDLE and index=0, including reset asserted mid-transfer. A partially completed transfer is abandoned and not resumed.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - start & legal op: latch pid, op, dir, mem_base; index=0; go to RD.
  - start & illegal op: err=1 for one cycle; stay in IDLE; no strobes.
- RD:
  - Present index with mem_addr/adder address; source memory reads.
  - hd_we=0, mem_we=0. Go to WR.
- WR:
  - Source data (mem_rdata if dir=0, hd_rdata if dir=1) routes combinationally to hd_wdata/mem_wdata.
  - Assert hd_we (dir=0) or mem_we (dir=1) for exactly this cycle, at the same index.
  - If index==WORDS-1, go to DONE; else index+1 and go to RD.
- DONE: done=1 and busy=1 for one cycle; index returns to 0; go to IDLE.
- Latency: start accepted at cycle 0; word k written at cycle 2k+2; done at cycle 2*WORDS+1.
- start while busy: ignored, no queuing.
- index never wraps past WORDS-1.
- Latched pid/op/dir/mem_base are stable for the whole transfer; input changes after start have no effect.
- mem_addr arithmetic: modulo 2^MADDR_W; wrap past the top of memory is the caller's responsibility.
- Never assert hd_we and mem_we together; never assert either outside WR.
- pid_buffer and flag_inst_type hold their last latched values in IDLE.

Optional Feature:
Macro XFER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_W-1:0].
  - Cleared on accepted start.
  - checksum = checksum + written word (mod 2^DATA_W) on every WR cycle.
  - Value is stable and valid while done=1, held until next start; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - op encodings OP_CONTEXT=2'b01 and OP_PAGE=2'b10 (also used by the control unit and address adder).
  - dir encodings DIR_SAVE=0, DIR_LOAD=1.
  - FSM state typedef.
- One sub-module: xfer_index_ctr, an 8-bit counter with clear, enable and terminal-count flag at WORDS-1.
- FSM and datapath stay in page_xfer_seq.

Test Plan:
- Reset, then start op=10 dir=0 pid=3 mem_base=100 -> 40 hd_we pulses at cycles 2,4,...,80 with index 0..39, mem_addr 100..139, flag_inst_type=10, pid_buffer=3; done at cycle 81; mem_we never high.
- start op=01 dir=1 pid=5, HD model returns 0xA000+index -> mem_we writes 0xA000..0xA027 to mem_base..mem_base+39; done once.
- start op=00 and op=11 in IDLE -> err one cycle; busy/hd_we/mem_we stay 0.
- Second start at cycle 10 of active transfer, with changed pid -> ignored; pid_buffer unchanged; exactly 40 writes.
- reset low at cycle 20 -> all outputs 0 immediately; after release, a new start performs a full transfer from index 0.
- With XFER_CHECKSUM_EN, transfer words 1..40 -> checksum=820 while done=1, held after.
